// File: rtl/simd_pkg.sv
// Shared constants and types for the SIMD deinterleaver datapath.
package simd_pkg;

    localparam int SIMD_WIDTH = 256;
    localparam int HALF_WIDTH = SIMD_WIDTH / 2;

    localparam logic [2:0] MODE_8    = 3'd0;
    localparam logic [2:0] MODE_16   = 3'd1;
    localparam logic [2:0] MODE_32   = 3'd2;
    localparam logic [2:0] MODE_64   = 3'd3;
    localparam logic [2:0] MODE_128  = 3'd4;
    localparam logic [2:0] MODE_PASS = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Codes 5..7 all mean a single full-width passthrough beat.
    function automatic logic is_pass(input logic [2:0] mode);
        return mode >= MODE_PASS;
    endfunction

endpackage

// File: rtl/simd_deint_lane.sv
// Combinational beat decoder: splits one interleaved beat into
// the A and B halves for the given element width.
module simd_deint_lane
    import simd_pkg::*;
(
    input  logic [SIMD_WIDTH-1:0] in_data,
    input  logic [2:0]            mode,
    output logic [HALF_WIDTH-1:0] a_half,
    output logic [HALF_WIDTH-1:0] b_half
);

    always_comb begin
        // 128b layout doubles as the don't-care value for passthrough.
        a_half = in_data[SIMD_WIDTH-1:HALF_WIDTH];
        b_half = in_data[HALF_WIDTH-1:0];
        case (mode)
            MODE_8: begin
                for (int i = 0; i < 16; i++) begin
                    b_half[i*8 +: 8] = in_data[(2*i)*8 +: 8];
                    a_half[i*8 +: 8] = in_data[(2*i+1)*8 +: 8];
                end
            end
            MODE_16: begin
                for (int i = 0; i < 8; i++) begin
                    b_half[i*16 +: 16] = in_data[(2*i)*16 +: 16];
                    a_half[i*16 +: 16] = in_data[(2*i+1)*16 +: 16];
                end
            end
            MODE_32: begin
                for (int i = 0; i < 4; i++) begin
                    b_half[i*32 +: 32] = in_data[(2*i)*32 +: 32];
                    a_half[i*32 +: 32] = in_data[(2*i+1)*32 +: 32];
                end
            end
            MODE_64: begin
                for (int i = 0; i < 2; i++) begin
                    b_half[i*64 +: 64] = in_data[(2*i)*64 +: 64];
                    a_half[i*64 +: 64] = in_data[(2*i+1)*64 +: 64];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/simd_deinterleaver.sv
// Rebuilds operands A and B from an UNPCKLO/UNPCKHI beat pair.
// Define SIMD_DEINT_MODE_CHECK_EN to build the lo/hi mode check.
module simd_deinterleaver #(
    parameter int SIMD_WIDTH = simd_pkg::SIMD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIMD_WIDTH-1:0] in_data,
    input  logic [2:0]            in_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SIMD_WIDTH-1:0] out_a,
    output logic [SIMD_WIDTH-1:0] out_b,
    output logic [2:0]            out_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    import simd_pkg::*;

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            mode_q;
    logic [HALF_WIDTH-1:0] lo_a_q;
    logic [HALF_WIDTH-1:0] lo_b_q;
    logic [HALF_WIDTH-1:0] lane_a;
    logic [HALF_WIDTH-1:0] lane_b;
    logic [2:0]            lane_mode;
    logic                  accept;
    logic                  hi_beat;

    assign accept    = in_valid && in_ready;
    assign hi_beat   = (state_q == WAIT_HI);
    // The hi beat is always decoded with the mode of its lo beat.
    assign lane_mode = hi_beat ? mode_q : in_mode;

    simd_deint_lane u_lane (
        .in_data (in_data),
        .mode    (lane_mode),
        .a_half  (lane_a),
        .b_half  (lane_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FULL: begin
                if (accept) begin
                    state_d = is_pass(in_mode) ? FULL : WAIT_HI;
                end else if (state_q == FULL && out_ready) begin
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != FULL) || out_ready;
        out_valid = (state_q == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= '0;
            lo_a_q   <= '0;
            lo_b_q   <= '0;
            out_a    <= '0;
            out_b    <= '0;
            out_mode <= '0;
        end else if (accept) begin
            if (hi_beat) begin
                out_a    <= {lane_a, lo_a_q};
                out_b    <= {lane_b, lo_b_q};
                out_mode <= mode_q;
            end else if (is_pass(in_mode)) begin
                out_a    <= in_data;
                out_b    <= '0;
                out_mode <= in_mode;
            end else begin
                lo_a_q <= lane_a;
                lo_b_q <= lane_b;
                mode_q <= in_mode;
            end
        end
    end

`ifdef SIMD_DEINT_MODE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && hi_beat && in_mode != mode_q) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_simd_deinterleaver.sv
// Randomized self-checking bench for simd_deinterleaver.
module tb_simd_deinterleaver;

    logic         clk;
    logic         rst_n;
    logic [255:0] in_data;
    logic [2:0]   in_mode;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] out_a;
    logic [255:0] out_b;
    logic [2:0]   out_mode;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    int checks;
    int errors;

`ifdef SIMD_DEINT_MODE_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    simd_deinterleaver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_mode  (out_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: a beat is a list of W-bit elements; even ones belong
    // to B, odd ones to A; lo beat builds the low halves, hi the high.
    function automatic logic [511:0] ref_pair(input logic [255:0] lo,
                                              input logic [255:0] hi,
                                              input logic [2:0] m);
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] beat;
        int w;
        a = '0;
        b = '0;
        if (m >= 3'd5) return {lo, 256'b0};
        w = 8 << m;
        for (int h = 0; h < 2; h++) begin
            beat = (h == 0) ? lo : hi;
            for (int e = 0; e < 256 / w; e++) begin
                for (int j = 0; j < w; j++) begin
                    if (e % 2 == 1) a[h*128 + (e/2)*w + j] = beat[e*w + j];
                    else            b[h*128 + (e/2)*w + j] = beat[e*w + j];
                end
            end
        end
        return {a, b};
    endfunction

    task automatic send(input logic [255:0] d, input logic [2:0] m);
        int n;
        @(negedge clk);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            $display("FAIL send_timeout in_ready=%b need 1", in_ready);
            errors++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
            $display("FAIL reset_ctl rdy=%b vld=%b err=%b need 1 0 0",
                     in_ready, out_valid, err);
            errors++;
        end
        checks++;
        if (out_a !== '0 || out_b !== '0 || out_mode !== 3'd0) begin
            $display("FAIL reset_data a=%h b=%h m=%0d need zero",
                     out_a, out_b, out_mode);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL post_reset rdy=%b vld=%b need 1 0",
                     in_ready, out_valid);
            errors++;
        end
    endtask

    task automatic test_mode8();
        logic [255:0] lo;
        logic [255:0] hi;
        logic [255:0] ea;
        logic [255:0] eb;
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            lo[(2*i)*8 +: 8]   = 8'h80 + 8'(i);
            lo[(2*i+1)*8 +: 8] = 8'(i);
            hi[(2*i)*8 +: 8]   = 8'h90 + 8'(i);
            hi[(2*i+1)*8 +: 8] = 8'h10 + 8'(i);
        end
        for (int k = 0; k < 32; k++) begin
            ea[k*8 +: 8] = 8'(k);
            eb[k*8 +: 8] = 8'h80 + 8'(k);
        end
        out_ready = 1'b1;
        send(lo, 3'd0);
        send(hi, 3'd0);
        @(negedge clk);
        r = ref_pair(lo, hi, 3'd0);
        checks++;
        if (out_valid !== 1'b1 || out_a !== ea || out_b !== eb) begin
            $display("FAIL mode8 vld=%b a=%h b=%h need a=%h b=%h",
                     out_valid, out_a, out_b, ea, eb);
            errors++;
        end
        checks++;
        if (out_a !== r[511:256] || out_b !== r[255:0] || out_mode !== 3'd0) begin
            $display("FAIL mode8_model a=%h need %h m=%0d",
                     out_a, r[511:256], out_mode);
            errors++;
        end
    endtask

    task automatic test_mode128();
        logic [255:0] ea;
        logic [255:0] eb;
        ea = {128'hA1, 128'hA0};
        eb = {128'hB1, 128'hB0};
        out_ready = 1'b1;
        send({128'hA0, 128'hB0}, 3'd4);
        send({128'hA1, 128'hB1}, 3'd4);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_a !== ea || out_b !== eb
            || out_mode !== 3'd4) begin
            $display("FAIL mode128 a=%h b=%h need %h %h",
                     out_a, out_b, ea, eb);
            errors++;
        end
    endtask

    task automatic test_passthrough();
        out_ready = 1'b1;
        @(negedge clk);
        in_data  = 256'h1234;
        in_mode  = 3'd5;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_a !== 256'h1234 || out_b !== '0
                || in_ready !== 1'b1) begin
                $display("FAIL pass_%0d vld=%b a=%h b=%h rdy=%b", c,
                         out_valid, out_a, out_b, in_ready);
                errors++;
            end
            if (c == 2) in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL pass_drain vld=%b need 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] lo;
        logic [255:0] hi;
        logic [511:0] r;
        lo = rand256();
        hi = rand256();
        r  = ref_pair(lo, hi, 3'd2);
        out_ready = 1'b1;
        send(lo, 3'd2);
        out_ready = 1'b0;
        send(hi, 3'd2);
        @(negedge clk);
        lo = rand256();
        hi = rand256();
        in_data  = lo;
        in_mode  = 3'd2;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1
                || out_a !== r[511:256] || out_b !== r[255:0]) begin
                $display("FAIL bp_hold_%0d rdy=%b vld=%b a=%h need %h", c,
                         in_ready, out_valid, out_a, r[511:256]);
                errors++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_release rdy=%b need 1", in_ready);
            errors++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_wait_hi vld=%b rdy=%b need 0 1",
                     out_valid, in_ready);
            errors++;
        end
        r = ref_pair(lo, hi, 3'd2);
        send(hi, 3'd2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_a !== r[511:256] || out_b !== r[255:0]) begin
            $display("FAIL bp_next a=%h b=%h need %h %h",
                     out_a, out_b, r[511:256], r[255:0]);
            errors++;
        end
    endtask

    task automatic test_mismatch();
        logic [255:0] lo;
        logic [255:0] hi;
        logic [511:0] r;
        lo = rand256();
        hi = rand256();
        r  = ref_pair(lo, hi, 3'd1);
        out_ready = 1'b1;
        send(lo, 3'd1);
        send(hi, 3'd3);
        @(negedge clk);
        checks++;
        if (err !== ERR_ON) begin
            $display("FAIL mm_err err=%b need %b", err, ERR_ON);
            errors++;
        end
        checks++;
        if (out_mode !== 3'd1 || out_a !== r[511:256] || out_b !== r[255:0]) begin
            $display("FAIL mm_decode m=%0d a=%h need m=1 a=%h",
                     out_mode, out_a, r[511:256]);
            errors++;
        end
        send(rand256(), 3'd0);
        send(rand256(), 3'd0);
        @(negedge clk);
        checks++;
        if (err !== ERR_ON) begin
            $display("FAIL mm_sticky err=%b need %b", err, ERR_ON);
            errors++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            $display("FAIL mm_clear err=%b need 0", err);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_wait_hi();
        logic [255:0] lo;
        logic [255:0] hi;
        logic [511:0] r;
        out_ready = 1'b1;
        send(rand256(), 3'd3);
        send(rand256(), 3'd3);
        send(rand256(), 3'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_a !== '0 || out_b !== '0
            || in_ready !== 1'b1) begin
            $display("FAIL rst_wait vld=%b a=%h rdy=%b need 0 0 1",
                     out_valid, out_a, in_ready);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        lo = rand256();
        hi = rand256();
        r  = ref_pair(lo, hi, 3'd0);
        send(lo, 3'd0);
        send(hi, 3'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_a !== r[511:256] || out_b !== r[255:0]) begin
            $display("FAIL rst_fresh a=%h b=%h need %h %h",
                     out_a, out_b, r[511:256], r[255:0]);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [255:0] lo;
        logic [255:0] hi;
        logic [511:0] r;
        logic [2:0]   m;
        int           k;
        for (int t = 0; t < 40; t++) begin
            m  = 3'($urandom_range(0, 7));
            lo = rand256();
            hi = rand256();
            r  = ref_pair(lo, hi, m);
            out_ready = 1'b1;
            send(lo, m);
            if (m < 3'd5) send(hi, m);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_a !== r[511:256]
                || out_b !== r[255:0] || out_mode !== m) begin
                $display("FAIL rand_%0d m=%0d a=%h b=%h need %h %h", t, m,
                         out_a, out_b, r[511:256], r[255:0]);
                errors++;
            end
            k = $urandom_range(0, 3);
            if (k > 0) out_ready = 1'b0;
            for (int c = 0; c < k; c++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_a !== r[511:256]
                    || out_b !== r[255:0]) begin
                    $display("FAIL rand_hold_%0d vld=%b a=%h need %h", t,
                             out_valid, out_a, r[511:256]);
                    errors++;
                end
            end
            out_ready = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mode8();
        test_mode128();
        test_passthrough();
        test_backpressure();
        test_mismatch();
        test_reset_wait_hi();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_deinterleaver.md
# simd_deinterleaver

Inverse of the SIMD unpack-interleave stage. The block accepts the low-half (UNPCKLO) result beat followed by the high-half (UNPCKHI) result beat. It separates the interleaved elements back into the two original 256-bit operands A and B and presents them on a registered valid/ready output. It sits after the packer in the ALU result path and feeds the operand-writeback logic.

## Interface
Parameters:
- SIMD_WIDTH, 256, vector width in bits; only 256 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  256  one interleaved beat.
- in_mode  in  3  element width code: 0=8b, 1=16b, 2=32b, 3=64b, 4=128b, 5–7=256b passthrough.
- in_valid  in  1  in_data and in_mode are valid.
- in_ready  out  1  the block accepts the beat this cycle.
- out_a  out  256  reconstructed A.
- out_b  out  256  reconstructed B.
- out_mode  out  3  mode latched from the lo beat.
- out_valid  out  1  out_a, out_b and out_mode are valid.
- out_ready  in  1  downstream accepts the output.
- err  out  1  sticky flag: lo and hi beats carried different modes.

## Operation
- Beat decode for mode d with element width W=8<<d and N=128/W: element 2i of the beat goes to the B half at element i; element 2i+1 goes to the A half at element i, for i=0..N-1.
- Mode 4 (128b): beat[255:128] goes to the A half, beat[127:0] goes to the B half.
- The lo beat fills A[127:0] and B[127:0]. The hi beat fills A[255:128] and B[255:128].
- Mode 5–7 is a single beat: out_a=in_data, out_b=0.
- FSM states:
  - IDLE → WAIT_HI on lo-beat accept when mode<5. The block latches the mode and the low halves.
  - IDLE → FULL on accept when mode≥5.
  - WAIT_HI → FULL on hi-beat accept. The block writes the high halves.
  - FULL → IDLE on out_ready with no input accept.
  - FULL with out_ready and in_valid: the new beat is accepted as a lo beat. The state moves to WAIT_HI, or stays FULL if mode≥5.
- in_ready = (state != FULL) || out_ready.
- The mode used for the hi-beat decode is the latched mode, not in_mode.
- Mode mismatch (only with the check macro): the hi beat's in_mode differs from the latched mode.
  - err is set on the next edge.
  - The beat is still accepted and decoded with the latched mode.
  - err clears only on reset.
- Reset mid-operation: any partial lo beat is discarded and the state returns to IDLE.
- Reset values: state IDLE, out_a=0, out_b=0, out_mode=0, out_valid=0, err=0.
  - in_ready reads 1 during and after reset.

## Timing
- Latency: out_valid rises 1 cycle after the hi beat is accepted. In passthrough mode it rises 1 cycle after the single beat is accepted.
- Throughput: one result every 2 accepted beats, with no bubble while out_ready=1. Passthrough gives one result per cycle.
- Output is stable from out_valid rising until out_valid && out_ready.
- A beat is transferred only when in_valid && in_ready.
- in_valid may drop between the lo and hi beats; WAIT_HI holds indefinitely.
- No combinational path from in_data to out_a or out_b. The only combinational path from out_ready is to in_ready.

## Configuration
- SIMD_DEINT_MODE_CHECK_EN defined: the mismatch comparator and the sticky err register are built.
- Macro undefined: err is tied to 0 and in_mode on the hi beat is ignored. All other behaviour is identical.

## Structure
- Shared package simd_pkg holds:
  - SIMD_WIDTH;
  - the mode codes MODE_8 … MODE_128 and MODE_PASS;
  - the FSM state type with IDLE, WAIT_HI and FULL.
- Sub-module simd_deint_lane is purely combinational. It maps in_data and mode to a_half[127:0] and b_half[127:0], and is instantiated once.
- The top level holds the FSM, the half registers and the output registers.

## Test plan
- Mode 0, out_ready=1:
  - Stimulus: lo beat with byte 2i=0x80+i and byte 2i+1=i; then hi beat with byte 2i=0x90+i and byte 2i+1=0x10+i, for i=0..15.
  - Response: 1 cycle after the hi beat, out_a byte k=k and out_b byte k=0x80+k.
- Mode 4:
  - Stimulus: lo={128'hA0,128'hB0}, then hi={128'hA1,128'hB1}.
  - Response: out_a={128'hA1,128'hA0} and out_b={128'hB1,128'hB0}.
- Mode 5:
  - Stimulus: in_data=256'h1234 on three consecutive cycles with out_ready=1.
  - Response: 3 results on consecutive cycles, each out_a=256'h1234, out_b=0, in_ready held at 1.
- Backpressure:
  - Stimulus: out_ready=0 after one mode-2 pair completes, with a new lo beat presented.
  - Response: in_ready=0 and the outputs hold. After out_ready=1 the lo beat is accepted in that same cycle and the state becomes WAIT_HI.
- Mismatch (macro on):
  - Stimulus: lo beat with mode 1, then hi beat with mode 3.
  - Response: err=1 from the next cycle; the output is decoded as mode 1; err stays 1 until rst_n=0.
- Reset in WAIT_HI:
  - Stimulus: assert rst_n=0 in WAIT_HI, then send a fresh mode-0 pair.
  - Response: out_valid=0 and out_a=0 immediately on reset; the fresh pair yields the correct result and nothing from the stale lo beat appears.
